// File: rtl/prog_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_ctrl
// Purpose  : Arbitrates a single-port program memory between a sequential
//            program loader and the core fetch unit. Fetch is blocked until
//            a load completes. The block reports the length of the last
//            completed load.
// Ports    :
//   clk, rstn          - clock (rising edge) / synchronous active-low reset
//   ld_start           - pulse: start a new load at address 0
//   ld_valid/ld_ready  - loader word handshake
//   ld_data, ld_last   - loader word and end-of-program marker
//   ld_done            - pulse: load complete
//   prog_len           - words written by the last completed load (0..32)
//   run                - fetch permitted
//   fetch_req/_addr    - fetch request and address
//   fetch_gnt          - fetch accepted this cycle
//   fetch_valid/_data  - fetched word, one cycle after the grant
//   mem_w, mem_addr,
//   mem_data_wr        - memory control/write pins
//   mem_data           - memory read data (registered inside the memory)
// Revision : 1.0 - initial release
// ============================================================================
module prog_mem_ctrl #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [DATA_SIZE-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_done,
  output logic [ADDR_SIZE:0]   prog_len,
  output logic                 run,
  input  logic                 fetch_req,
  input  logic [ADDR_SIZE-1:0] fetch_addr,
  output logic                 fetch_gnt,
  output logic                 fetch_valid,
  output logic [DATA_SIZE-1:0] fetch_data,
  output logic                 mem_w,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_data_wr,
  input  logic [DATA_SIZE-1:0] mem_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  localparam logic [ADDR_SIZE-1:0] C_ADDR_MAX = '1;
  localparam logic [ADDR_SIZE-1:0] C_PTR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0]   C_LEN_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0]   prog_len_q, prog_len_d;
  logic                 ld_done_q, ld_done_d;
  logic                 fetch_valid_q;

  // Next-state and combinational memory/handshake outputs
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    prog_len_d  = prog_len_q;
    ld_done_d   = 1'b0;
    ld_ready    = 1'b0;
    fetch_gnt   = 1'b0;
    mem_w       = 1'b0;
    mem_addr    = fetch_addr;
    mem_data_wr = ld_data;

    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
        end
      end

      S_LOAD: begin
        mem_addr = wr_ptr_q;
        if (ld_start) begin
          // Restart: a beat presented with ld_start is refused and not written
          wr_ptr_d = '0;
        end else begin
          ld_ready = 1'b1;
          mem_w    = ld_valid;
          if (ld_valid) begin
            // The beat at the top address ends the load even without ld_last,
            // so the pointer never wraps.
            if (ld_last || (wr_ptr_q == C_ADDR_MAX)) begin
              state_d    = S_RUN;
              prog_len_d = {1'b0, wr_ptr_q} + C_LEN_ONE;
              ld_done_d  = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
          end
        end
      end

      S_RUN: begin
        // A new load takes priority over fetch in the same cycle
        fetch_gnt = fetch_req & ~ld_start;
        if (ld_start) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      ld_done_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      prog_len_q    <= prog_len_d;
      ld_done_q     <= ld_done_d;
      // Tracks the grant only, so a fetch granted in the last RUN cycle
      // still completes after the state has moved on.
      fetch_valid_q <= fetch_gnt;
    end
  end

  assign run         = (state_q == S_RUN);
  assign ld_done     = ld_done_q;
  assign prog_len    = prog_len_q;
  assign fetch_valid = fetch_valid_q;
  // The memory output register already holds the word in the cycle after the
  // grant. Forward it directly so that latency stays at one cycle. Hold zero
  // when no fetch is completing.
  assign fetch_data  = fetch_valid_q ? mem_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mem_ctrl
// Purpose  : Self-checking bench for prog_mem_ctrl with a behavioural
//            registered-read memory and a fetch-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_mem_ctrl;

  localparam int DW = 6;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ld_start, ld_valid, ld_ready, ld_last, ld_done;
  logic [DW-1:0] ld_data;
  logic [AW:0]   prog_len;
  logic          run, fetch_req, fetch_gnt, fetch_valid;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_wr;
  logic [DW-1:0] mem_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] tb_mem [32];
  logic [DW-1:0] sh     [32];
  logic [DW-1:0] sb_q   [$];

  prog_mem_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_done    (ld_done),
    .prog_len   (prog_len),
    .run        (run),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_gnt  (fetch_gnt),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .mem_w      (mem_w),
    .mem_addr   (mem_addr),
    .mem_data_wr(mem_data_wr),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural program memory: write on mem_w, otherwise registered read
  always @(posedge clk) begin
    if (mem_w) tb_mem[mem_addr] <= mem_data_wr;
    else       mem_data         <= tb_mem[mem_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every completed fetch must match the oldest expected word
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL fetch_unexpected: got data %0d expected no fetch_valid", fetch_data);
      end else begin
        chk("fetch_data", int'(fetch_data), int'(sb_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic          rstn, ld_start, ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last, fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          e_ready, e_mem_w, chk_addr;
    logic [AW-1:0] e_addr;
    logic          e_gnt, e_run, e_done, e_fv;
    logic [AW:0]   e_len;
    logic [DW-1:0] e_fdata;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_start   = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
  endtask

  initial begin
    //          rstn st lv data   last fr faddr rdy mw ca addr gnt run done fv len fdata
    vecs[0] = '{1'b0,1'b0,1'b1,6'h00,1'b0,1'b1,5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,6'd0,6'h00};
    vecs[1] = '{1'b0,1'b0,1'b1,6'h00,1'b0,1'b1,5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,6'd0,6'h00};
    vecs[2] = '{1'b1,1'b1,1'b0,6'h00,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,6'd0,6'h00};
    vecs[3] = '{1'b1,1'b0,1'b1,6'h11,1'b0,1'b0,5'd0, 1'b1,1'b1,1'b1,5'd0, 1'b0,1'b0,1'b0,1'b0,6'd0,6'h00};
    vecs[4] = '{1'b1,1'b0,1'b1,6'h22,1'b0,1'b0,5'd0, 1'b1,1'b1,1'b1,5'd1, 1'b0,1'b0,1'b0,1'b0,6'd0,6'h00};
    vecs[5] = '{1'b1,1'b0,1'b1,6'h33,1'b1,1'b0,5'd0, 1'b1,1'b1,1'b1,5'd2, 1'b0,1'b0,1'b0,1'b0,6'd0,6'h00};
    vecs[6] = '{1'b1,1'b0,1'b0,6'h00,1'b0,1'b1,5'd1, 1'b0,1'b0,1'b1,5'd1, 1'b1,1'b1,1'b1,1'b0,6'd3,6'h22};
    vecs[7] = '{1'b1,1'b0,1'b0,6'h00,1'b0,1'b1,5'd2, 1'b0,1'b0,1'b1,5'd2, 1'b1,1'b1,1'b0,1'b1,6'd3,6'h33};
    vecs[8] = '{1'b1,1'b0,1'b0,6'h00,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b1,6'd3,6'h00};
    vecs[9] = '{1'b1,1'b0,1'b0,6'h00,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,6'd3,6'h00};

    // Hold reset across the first edge so every table row sees a known state
    rstn = 1'b0;
    idle_inputs();
    ld_valid  = 1'b1;
    fetch_req = 1'b1;
    tick();

    // ---------------- table: reset, 3-word load, back-to-back fetch ----------
    for (int i = 0; i < 10; i++) begin
      rstn       = vecs[i].rstn;
      ld_start   = vecs[i].ld_start;
      ld_valid   = vecs[i].ld_valid;
      ld_data    = vecs[i].ld_data;
      ld_last    = vecs[i].ld_last;
      fetch_req  = vecs[i].fetch_req;
      fetch_addr = vecs[i].fetch_addr;
      #3;
      chk($sformatf("v%0d_ld_ready", i), int'(ld_ready), int'(vecs[i].e_ready));
      chk($sformatf("v%0d_mem_w", i), int'(mem_w), int'(vecs[i].e_mem_w));
      if (vecs[i].chk_addr)
        chk($sformatf("v%0d_mem_addr", i), int'(mem_addr), int'(vecs[i].e_addr));
      if (vecs[i].e_mem_w)
        chk($sformatf("v%0d_mem_data_wr", i), int'(mem_data_wr), int'(vecs[i].ld_data));
      chk($sformatf("v%0d_fetch_gnt", i), int'(fetch_gnt), int'(vecs[i].e_gnt));
      chk($sformatf("v%0d_run", i), int'(run), int'(vecs[i].e_run));
      chk($sformatf("v%0d_ld_done", i), int'(ld_done), int'(vecs[i].e_done));
      chk($sformatf("v%0d_fetch_valid", i), int'(fetch_valid), int'(vecs[i].e_fv));
      chk($sformatf("v%0d_prog_len", i), int'(prog_len), int'(vecs[i].e_len));
      if (vecs[i].e_gnt) sb_q.push_back(vecs[i].e_fdata);
      tick();
    end
    sh[0] = 6'h11; sh[1] = 6'h22; sh[2] = 6'h33;

    // ---------------- full memory: 32 beats without ld_last ------------------
    idle_inputs();
    ld_start = 1'b1;
    #3;
    chk("full_start_gnt", int'(fetch_gnt), 0);
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'((i * 5 + 3) % 64);
      sh[i]    = ld_data;
      #3;
      chk($sformatf("full_ready_%0d", i), int'(ld_ready), 1);
      chk($sformatf("full_addr_%0d", i), int'(mem_addr), i);
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = 6'h3F;
    #3;
    chk("full_33rd_ready", int'(ld_ready), 0);
    chk("full_33rd_mem_w", int'(mem_w), 0);
    chk("full_ld_done", int'(ld_done), 1);
    chk("full_prog_len", int'(prog_len), 32);
    chk("full_run", int'(run), 1);
    tick();
    ld_valid = 1'b0;
    #3;
    chk("full_done_pulse", int'(ld_done), 0);
    for (int k = 0; k < 3; k++) begin
      fetch_req  = 1'b1;
      fetch_addr = (k == 0) ? 5'd31 : (k == 1) ? 5'd0 : 5'd17;
      #3;
      chk($sformatf("full_fetch_gnt_%0d", k), int'(fetch_gnt), 1);
      sb_q.push_back(sh[fetch_addr]);
      tick();
    end
    fetch_req = 1'b0;
    tick();
    tick();

    // ---------------- priority: ld_start beats fetch_req ----------------------
    fetch_req  = 1'b1;
    fetch_addr = 5'd5;
    #3;
    chk("prio_pre_gnt", int'(fetch_gnt), 1);
    sb_q.push_back(sh[5]);
    tick();
    ld_start   = 1'b1;
    fetch_addr = 5'd6;
    #3;
    chk("prio_gnt", int'(fetch_gnt), 0);
    chk("prio_prev_valid", int'(fetch_valid), 1);
    tick();
    ld_start   = 1'b0;
    fetch_addr = 5'd7;
    #3;
    chk("prio_valid_after", int'(fetch_valid), 0);
    chk("prio_gnt_load", int'(fetch_gnt), 0);
    chk("prio_run", int'(run), 0);
    chk("prio_ready", int'(ld_ready), 1);
    chk("prio_mem_addr", int'(mem_addr), 0);
    fetch_req = 1'b0;

    // ---------------- reset mid-load, then restart ----------------------------
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(5 + i);
      sh[i]    = ld_data;
      tick();
    end
    ld_valid = 1'b0;
    rstn     = 1'b0;
    tick();
    rstn       = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 5'd3;
    #3;
    chk("rst_run", int'(run), 0);
    chk("rst_prog_len", int'(prog_len), 0);
    chk("rst_idle_gnt", int'(fetch_gnt), 0);
    chk("rst_idle_ready", int'(ld_ready), 0);
    tick();
    fetch_req = 1'b0;
    ld_start  = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(32 + i);
      sh[i]    = ld_data;
      #3;
      chk($sformatf("rl_addr_%0d", i), int'(mem_addr), i);
      tick();
    end
    ld_start = 1'b1;
    ld_data  = 6'h3E;
    #3;
    chk("restart_ready", int'(ld_ready), 0);
    tick();
    ld_start = 1'b0;
    ld_data  = 6'h2A;
    ld_last  = 1'b1;
    sh[0]    = 6'h2A;
    #3;
    chk("restart_mem_addr", int'(mem_addr), 0);
    chk("restart_ready2", int'(ld_ready), 1);
    chk("restart_mem_w", int'(mem_w), 1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 5'd0;
    #3;
    chk("restart_done", int'(ld_done), 1);
    chk("restart_prog_len", int'(prog_len), 1);
    chk("restart_gnt0", int'(fetch_gnt), 1);
    sb_q.push_back(sh[0]);
    tick();
    fetch_addr = 5'd4;
    #3;
    chk("restart_gnt4", int'(fetch_gnt), 1);
    sb_q.push_back(sh[4]);
    tick();
    fetch_req = 1'b0;
    tick();
    tick();

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_mem_ctrl.md
Name: prog_mem_ctrl

Overview:
- Sequences and shares the 6-bit-wide, 32-entry program memory between two requesters.
- Requester 1 is a program loader: a byte-stream source, such as a debug or UART bridge, that writes instructions sequentially from address 0.
- Requester 2 is the core fetch unit, which reads instructions by address.
- The block owns the memory's write-enable, address and write-data pins, gates fetch until a program is loaded, and reports the loaded program length.

Parameters:
- DATA_SIZE, 6, instruction word width; equals the program memory data width.
- ADDR_SIZE, 5, program memory address width; depth is 2**ADDR_SIZE.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- ld_start  in  1  single-cycle pulse; begins a new load at address 0.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader word accepted this cycle when ld_valid is also high.
- ld_data  in  DATA_SIZE  loader instruction word.
- ld_last  in  1  marks the final word of the program; sampled with ld_valid.
- ld_done  out  1  single-cycle pulse; load complete.
- prog_len  out  ADDR_SIZE+1  number of words written by the last completed load.
- run  out  1  high while in RUN; fetch is permitted.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_SIZE  fetch address.
- fetch_gnt  out  1  fetch request accepted this cycle.
- fetch_valid  out  1  fetch data valid; registered.
- fetch_data  out  DATA_SIZE  fetched word.
- mem_w  out  1  memory write enable.
- mem_addr  out  ADDR_SIZE  memory address.
- mem_data_wr  out  DATA_SIZE  memory write data.
- mem_data  in  DATA_SIZE  memory read data; registered in memory, valid the cycle after the address is presented with mem_w=0.

Behaviour:
- Reset (rstn=0 at an edge):
  - state=IDLE, wr_ptr=0, prog_len=0.
  - ld_done=0, fetch_valid=0, fetch_data=0.
  - Reset mid-load abandons the load; prog_len stays 0.
- States: IDLE, LOAD, RUN.
- IDLE:
  - ld_ready=0, fetch_gnt=0, run=0.
  - ld_start -> LOAD, wr_ptr=0.
- LOAD:
  - ld_ready=1.
  - Combinational outputs: mem_w = ld_valid; mem_addr = wr_ptr; mem_data_wr = ld_data.
  - On an accepted beat, wr_ptr increments.
  - If ld_last=1, or wr_ptr=2**ADDR_SIZE-1 (memory full), then next state is RUN, prog_len = wr_ptr+1, and ld_done pulses in the following cycle.
  - A full memory ends the load even if ld_last=0. Beats beyond that point are not accepted because ld_ready=0 outside LOAD.
  - ld_start while in LOAD restarts the load: wr_ptr=0, and any beat in that same cycle is not accepted (ld_ready=0 that cycle).
- RUN:
  - run=1.
  - Combinational outputs: fetch_gnt = fetch_req & ~ld_start; mem_w=0; mem_addr = fetch_addr.
  - One cycle after a grant: fetch_valid=1 and fetch_data=mem_data (captured from memory output).
  - Latency from fetch_req to fetch_valid is 1 cycle. Back-to-back grants are allowed, giving 1 word per cycle throughput.
  - ld_start has priority over fetch_req: transition to LOAD, wr_ptr=0, no grant in that cycle.
  - A fetch granted in the last RUN cycle still returns fetch_valid in the next cycle, even though the state is then LOAD.
- Outside RUN: fetch_gnt=0, and fetch_valid=0 unless it completes an already-granted fetch.
- mem_addr outside LOAD and RUN is fetch_addr (don't-care); mem_w=0.
- Widths:
  - wr_ptr is ADDR_SIZE bits and never wraps; a full memory terminates the load.
  - prog_len is ADDR_SIZE+1 bits so the value 32 is representable.

Test Plan:
- Reset: rstn=0 for 2 cycles with ld_valid=1 and fetch_req=1 -> mem_w=0, fetch_gnt=0, fetch_valid=0, prog_len=0, run=0.
- Load 3 words: ld_start, then 0x11, 0x22, 0x33 (last) on consecutive cycles.
  - mem_w high for 3 cycles at addresses 0, 1, 2.
  - ld_done pulses 1 cycle after the last beat.
  - prog_len=3, run=1.
- Fetch after that load: fetch_req addr 1, then addr 2, back-to-back.
  - fetch_gnt=1 in both cycles.
  - fetch_valid=1 with data 0x22, then 0x33, each 1 cycle after its grant.
- Full memory: load 32 words without ld_last.
  - Terminates after the beat at address 31; prog_len=32.
  - A 33rd ld_valid beat sees ld_ready=0.
- Priority: in RUN, ld_start and fetch_req asserted together.
  - fetch_gnt=0, state goes to LOAD, fetch_valid=0 next cycle.
  - A separate fetch granted 1 cycle before ld_start still returns fetch_valid.
- Reset and restart: rstn=0 after 2 load beats.
  - State returns to IDLE, prog_len=0.
  - A fetch_req during IDLE gets fetch_gnt=0.
  - A ld_start during LOAD after 5 beats restarts at mem_addr=0.
